// File: rtl/top_mul_pkg.sv
// top_mul_pkg: shared constants and width helpers for the pipelined multiplier.
package top_mul_pkg;
  localparam int SIGN_A = 0;
  localparam int SIGN_B = 1;
  function automatic int ext_prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction
endpackage

// File: rtl/top_mul_pipe_stage.sv
// top_mul_pipe_stage: one pipeline register (valid, data, tag) that loads when enabled and holds otherwise.
module top_mul_pipe_stage #(
  parameter int DW = 92,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic [TW-1:0] tag_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [TW-1:0] tag_o
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] tag_q, tag_d;
  always_comb begin
    valid_d = load_i ? valid_i : valid_q;
    data_d  = load_i ? data_i : data_q;
    tag_d   = load_i ? tag_i : tag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;
endmodule

// File: rtl/top_mul_pipe_hs.sv
// top_mul_pipe_hs: pipelined signed/unsigned multiplier with valid/ready handshake and tag passthrough.
module top_mul_pipe_hs
  import top_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 64,
  parameter int dout_WIDTH = 92,
  parameter int NUM_STAGE  = 3,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [1:0]            in_signed,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);
  localparam int PW = ext_prod_width(din0_WIDTH, din1_WIDTH) + 0 * ID;
  logic [din0_WIDTH:0]        a_ext;
  logic [din1_WIDTH:0]        b_ext;
  logic signed [PW-1:0]       prod;
  logic [dout_WIDTH-1:0]      res;
  // one extra bit per operand lets a single signed multiply cover every signedness mix
  always_comb begin
    a_ext = {in_signed[SIGN_A] & din0[din0_WIDTH-1], din0};
    b_ext = {in_signed[SIGN_B] & din1[din1_WIDTH-1], din1};
    prod  = PW'($signed(a_ext)) * PW'($signed(b_ext));
    res   = dout_WIDTH'(prod);
  end
  if (NUM_STAGE == 0) begin : g_comb
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign dout      = res;
    assign out_tag   = in_tag;
    assign busy      = 1'b0;
  end else begin : g_pipe
    logic [NUM_STAGE:0]      v;
    logic [dout_WIDTH-1:0]   d [NUM_STAGE+1];
    logic [TAG_WIDTH-1:0]    t [NUM_STAGE+1];
    logic [NUM_STAGE+1:1]    en;
    assign v[0] = in_valid;
    assign d[0] = res;
    assign t[0] = in_tag;
    // a stage may load if it is empty or its successor is advancing, so bubbles collapse
    always_comb begin
      en[NUM_STAGE+1] = out_ready;
      for (int k = NUM_STAGE; k >= 1; k--) en[k] = !v[k] || en[k+1];
    end
    for (genvar s = 1; s <= NUM_STAGE; s++) begin : g_stage
      top_mul_pipe_stage #(.DW(dout_WIDTH), .TW(TAG_WIDTH)) u_stage (
        .clk(ap_clk), .rst(ap_rst), .load_i(en[s]),
        .valid_i(v[s-1]), .data_i(d[s-1]), .tag_i(t[s-1]),
        .valid_o(v[s]), .data_o(d[s]), .tag_o(t[s])
      );
    end
    assign in_ready  = en[1];
    assign out_valid = v[NUM_STAGE];
    assign dout      = d[NUM_STAGE];
    assign out_tag   = t[NUM_STAGE];
    assign busy      = |v[NUM_STAGE:1];
  end
endmodule

// File: tb/tb_top_mul_pipe_hs.sv
// tb_top_mul_pipe_hs: scoreboard bench for the 3-stage multiplier plus a combinational (NUM_STAGE=0) build.
module tb_top_mul_pipe_hs;
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [27:0] din0;
  logic [63:0] din1;
  logic [1:0]  in_signed;
  logic [3:0]  in_tag, out_tag;
  logic [91:0] dout, exp_cur;
  logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
  logic [27:0] z_din0;
  logic [63:0] z_din1;
  logic [1:0]  z_in_signed;
  logic [3:0]  z_in_tag, z_out_tag;
  logic [91:0] z_dout;
  always #5 ap_clk = ~ap_clk;

  top_mul_pipe_hs dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_tag(out_tag), .busy(busy)
  );
  top_mul_pipe_hs #(.NUM_STAGE(0)) dut_z (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .din0(z_din0), .din1(z_din1), .in_signed(z_in_signed), .in_tag(z_in_tag),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .dout(z_dout), .out_tag(z_out_tag), .busy(z_busy)
  );

  typedef struct { logic [27:0] d0; logic [63:0] d1; logic [1:0] sg; logic [91:0] exp; } vec_t;
  typedef struct { logic [3:0] tag; logic [91:0] dout; } sb_t;
  sb_t  q[$];
  sb_t  mon_e;
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [91:0] act, input logic [91:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %h dout %h expected no output", out_tag, dout);
        end else begin
          mon_e = q.pop_front();
          chk("sb_dout", dout, mon_e.dout);
          chk("sb_tag", 92'(out_tag), 92'(mon_e.tag));
        end
      end
      if (in_valid && in_ready) q.push_back('{in_tag, exp_cur});
    end
  end

  task automatic send(input logic [27:0] a, input logic [63:0] b, input logic [1:0] s,
                      input logic [3:0] t, input logic [91:0] e);
    int n = 0;
    din0 = a; din1 = b; in_signed = s; in_tag = t; exp_cur = e; in_valid = 1'b1;
    @(negedge ap_clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge ap_clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || busy) && n < 100) begin
      n++;
      @(negedge ap_clk);
    end
    chk("drain_empty", 92'(q.size()), 92'd0);
    chk("drain_busy", 92'(busy), 92'd0);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [91:0] held;
    int k;
    bit stale;
    tbl[0] = '{28'hFFFFFFF, 64'd2, 2'b00, 92'h1FFFFFFE};
    tbl[1] = '{28'hFFFFFFF, 64'd5, 2'b01, ~92'd4};
    tbl[2] = '{28'hFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 92'd1};
    tbl[3] = '{28'd3, 64'd7, 2'b00, 92'd21};
    tbl[4] = '{28'hFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 92'hFFFFFFE_FFFFFFFFF0000001};
    tbl[5] = '{28'd2, 64'hFFFF_FFFF_FFFF_FFFD, 2'b10, ~92'd5};
    tbl[6] = '{28'h7FFFFFF, 64'd4, 2'b01, 92'h1FFFFFFC};
    tbl[7] = '{28'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 92'hFFFF_FFFF_FFFF_FFFF};
    tbl[8] = '{28'h8000000, 64'h8000_0000_0000_0000, 2'b11, 92'd1 << 90};
    tbl[9] = '{28'd0, 64'h1234_5678_9ABC_DEF0, 2'b11, 92'd0};
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    din0 = '0; din1 = '0; in_signed = '0; in_tag = '0; exp_cur = '0;
    z_in_valid = 1'b0; z_out_ready = 1'b0; z_din0 = '0; z_din1 = '0; z_in_signed = '0; z_in_tag = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_out_valid", 92'(out_valid), 92'd0);
    chk("rst_busy", 92'(busy), 92'd0);
    chk("rst_dout", dout, 92'd0);
    chk("rst_out_tag", 92'(out_tag), 92'd0);
    chk("rst_in_ready", 92'(in_ready), 92'd1);
    @(posedge ap_clk);
    #1;
    send(28'hFFFFFFF, 64'd2, 2'b00, 4'd9, 92'h1FFFFFFE);
    in_valid = 1'b0;
    @(negedge ap_clk) chk("lat_c1", 92'(out_valid), 92'd0);
    @(negedge ap_clk) chk("lat_c2", 92'(out_valid), 92'd0);
    @(negedge ap_clk) chk("lat_c3", 92'(out_valid), 92'd1);
    drain();
    for (int i = 0; i < 10; i++) send(tbl[i].d0, tbl[i].d1, tbl[i].sg, 4'(i + 1), tbl[i].exp);
    drain();
    out_ready = 1'b0;
    k = 1;
    repeat (6) begin
      din0 = 28'(k); din1 = 64'd3; in_signed = 2'b00; in_tag = 4'(k); exp_cur = 92'(3 * k);
      in_valid = 1'b1;
      @(negedge ap_clk);
      if (in_ready) k++;
      @(posedge ap_clk);
      #1;
    end
    @(negedge ap_clk);
    chk("bp_accepted", 92'(k - 1), 92'd3);
    chk("bp_in_ready", 92'(in_ready), 92'd0);
    chk("bp_out_tag", 92'(out_tag), 92'd1);
    held = dout;
    repeat (3) @(negedge ap_clk);
    chk("bp_dout_stable", dout, held);
    @(posedge ap_clk);
    #1 out_ready = 1'b1;
    while (k <= 5) begin
      send(28'(k), 64'd3, 2'b00, 4'(k), 92'(3 * k));
      k++;
    end
    drain();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      din0 = 28'(j + 2); din1 = 64'd10; in_signed = 2'b00; in_tag = 4'(10 + j); exp_cur = 92'(10 * (j + 2));
      in_valid = 1'b1;
      @(negedge ap_clk) chk("bubble_in_ready", 92'(in_ready), 92'd1);
      @(posedge ap_clk);
      #1 in_valid = 1'b0;
      @(posedge ap_clk);
      #1;
    end
    @(negedge ap_clk);
    chk("bubble_full_in_ready", 92'(in_ready), 92'd0);
    chk("bubble_occupancy", 92'(q.size()), 92'd3);
    drain();
    out_ready = 1'b0;
    send(28'd5, 64'd5, 2'b00, 4'd7, 92'd25);
    send(28'd6, 64'd6, 2'b00, 4'd8, 92'd36);
    in_valid = 1'b0;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rstmid_out_valid", 92'(out_valid), 92'd0);
    chk("rstmid_busy", 92'(busy), 92'd0);
    chk("rstmid_in_ready", 92'(in_ready), 92'd1);
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (6) @(negedge ap_clk) if (out_valid) stale = 1'b1;
    chk("rstmid_no_stale", 92'(stale), 92'd0);
    z_din0 = 28'd3; z_din1 = 64'd7; z_in_tag = 4'd5; z_in_valid = 1'b1; z_out_ready = 1'b1;
    #1;
    chk("z_dout", z_dout, 92'd21);
    chk("z_out_valid", 92'(z_out_valid), 92'd1);
    chk("z_out_tag", 92'(z_out_tag), 92'd5);
    chk("z_in_ready_hi", 92'(z_in_ready), 92'd1);
    z_out_ready = 1'b0;
    #1;
    chk("z_in_ready_lo", 92'(z_in_ready), 92'd0);
    chk("z_busy", 92'(z_busy), 92'd0);
    z_din0 = 28'hFFFFFFF; z_din1 = 64'd5; z_in_signed = 2'b01;
    #1;
    chk("z_signed", z_dout, ~92'd4);
    chk("final_queue", 92'(q.size()), 92'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
